// File: rtl/gcd_sequencer.sv
// gcd_sequencer: control FSM for a 16-bit subtractive GCD datapath; optional step limit via GCD_SEQ_TIMEOUT_EN
module gcd_sequencer #(
    parameter int unsigned MAX_ITER = 65535,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  logic gt_i,
    input  logic lt_i,
    output logic ld_a_o,
    output logic ld_b_o,
    output logic sel1_o,
    output logic sel2_o,
    output logic sel_in_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             eq;
    assign eq      = ~gt_i & ~lt_i;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign busy_o  = state_q != IDLE;
`ifdef GCD_SEQ_TIMEOUT_EN
    logic err_q, err_d;
    assign err_o = (state_q == DONE) & err_q;
`else
    logic unused_max;
    assign unused_max = ^MAX_ITER;
    assign err_o      = 1'b0;
`endif
    // next-state and datapath control decode; gt wins when gt and lt are both set
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_o = 1'b0;
        ld_a_o     = 1'b0;
        ld_b_o     = 1'b0;
        sel1_o     = 1'b0;
        sel2_o     = 1'b0;
        sel_in_o   = 1'b0;
        done_o     = 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                state_d = LOAD_A;
                cnt_d   = '0;
`ifdef GCD_SEQ_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            LOAD_A: begin
                in_ready_o = 1'b1;
                sel_in_o   = 1'b1;
                ld_a_o     = in_valid_i;
                state_d    = in_valid_i ? LOAD_B : LOAD_A;
            end
            LOAD_B: begin
                in_ready_o = 1'b1;
                sel_in_o   = 1'b1;
                ld_b_o     = in_valid_i;
                state_d    = in_valid_i ? CMP : LOAD_B;
            end
            CMP: begin
                state_d = gt_i ? SUB_A : lt_i ? SUB_B : DONE;
`ifdef GCD_SEQ_TIMEOUT_EN
                if (!eq && cnt_q == CNT_W'(MAX_ITER)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
`endif
            end
            SUB_A: begin
                sel2_o  = 1'b1;
                ld_a_o  = 1'b1;
                cnt_d   = cnt_inc;
                state_d = CMP;
            end
            SUB_B: begin
                sel1_o  = 1'b1;
                ld_b_o  = 1'b1;
                cnt_d   = cnt_inc;
                state_d = CMP;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, step counter and abort flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef GCD_SEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end
    logic unused_eq;
    assign unused_eq = eq;
endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer: directed checks of the GCD sequencer against a behavioural datapath
module tb_gcd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0, in_valid_i = 1'b0;
    logic in_ready_o, ld_a_o, ld_b_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o;
    logic [15:0] data_i = '0, ra = '0, rb = '0;
    logic [15:0] bus;
    logic gt_i, lt_i;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    gcd_sequencer #(.MAX_ITER(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .gt_i(gt_i), .lt_i(lt_i), .ld_a_o(ld_a_o),
        .ld_b_o(ld_b_o), .sel1_o(sel1_o), .sel2_o(sel2_o), .sel_in_o(sel_in_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // behavioural datapath: bus mux, subtractor, A/B registers, comparator
    assign bus  = sel_in_o ? data_i : ((sel1_o ? rb : ra) - (sel2_o ? rb : ra));
    assign gt_i = ra > rb;
    assign lt_i = ra < rb;
    always @(posedge clk) begin
        if (ld_a_o) ra <= bus;
        if (ld_b_o) rb <= bus;
    end

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; data_i = a; in_valid_i = 1'b1;
        @(negedge clk); data_i = b;
        @(negedge clk); in_valid_i = 1'b0;
    endtask

    task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input int stall,
                           input int exp_lat, input logic [15:0] exp_a, input logic exp_err,
                           input bit poke, input string nm);
        int loads, st, done_at, extra;
        logic err_seen;
        loads = 0; st = 0; done_at = 0; extra = 0; err_seen = 1'b0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int n = 1; n <= 400 && done_at == 0; n++) begin
            start_i = poke && n >= 3 && n <= 6;
            in_valid_i = 1'b0;
            if (n == 1) begin
                checks++;
                if (busy_o !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", nm, busy_o); end
            end
            if (in_ready_o) begin
                if (loads == 0 && st < stall) begin
                    st++;
                    #1;
                    checks++;
                    if ({in_ready_o, ld_a_o} !== 2'b10) begin
                        errors++; $display("FAIL %s stall: ready,ldA=%b%b want 10", nm, in_ready_o, ld_a_o);
                    end
                end else begin
                    data_i = (loads == 0) ? a : b;
                    in_valid_i = 1'b1;
                    loads++;
                end
            end
            #1;
            if (done_o) begin done_at = n; err_seen = err_o; end
            else @(negedge clk);
        end
        start_i = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if (done_at != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, done_at, exp_lat); end
        checks++;
        if (ra !== exp_a) begin errors++; $display("FAIL %s result: got %0d want %0d", nm, ra, exp_a); end
        checks++;
        if (err_seen !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", nm, err_seen, exp_err); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        checks++;
        if (extra != 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL %s after_done: extra done=%0d busy=%b want 0/0", nm, extra, busy_o);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({in_ready_o, ld_a_o, ld_b_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o} !== 9'b0) begin
            errors++; $display("FAIL reset_low: outputs got %b want 0", {in_ready_o, ld_a_o, ld_b_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_o, ld_a_o, ld_b_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o} !== 9'b0) begin
            errors++; $display("FAIL reset_release: outputs got %b want 0", {in_ready_o, ld_a_o, ld_b_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o});
        end
    endtask

    task automatic test_basic;
        run_gcd(16'd36, 16'd24, 0, 8, 16'd12, 1'b0, 1'b0, "gcd_36_24");
        run_gcd(16'd7, 16'd7, 0, 4, 16'd7, 1'b0, 1'b0, "gcd_7_7");
        run_gcd(16'd5, 16'd15, 0, 8, 16'd5, 1'b0, 1'b0, "gcd_5_15");
    endtask

    task automatic test_stall;
        run_gcd(16'd36, 16'd24, 5, 13, 16'd12, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_start_ignored;
        run_gcd(16'd36, 16'd24, 0, 8, 16'd12, 1'b0, 1'b1, "start_busy");
    endtask

    task automatic test_zero_operand;
`ifdef GCD_SEQ_TIMEOUT_EN
        run_gcd(16'd0, 16'd5, 0, 36, 16'd0, 1'b1, 1'b0, "timeout");
        run_gcd(16'd9, 16'd6, 0, 8, 16'd3, 1'b0, 1'b0, "after_timeout");
`else
        int hold;
        hold = 0;
        load_ops(16'd0, 16'd5);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy_o && !done_o) hold++;
        end
        checks++;
        if (hold != 200) begin errors++; $display("FAIL zero_operand: busy cycles got %0d want 200", hold); end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
`endif
    endtask

    task automatic test_reset_midrun;
        bit found;
        found = 1'b0;
        load_ops(16'd36, 16'd24);
        for (int k = 0; k < 20 && !found; k++) begin
            if (ld_b_o && sel1_o) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midrun_reach_sub_b: got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ld_a_o, ld_b_o, busy_o, done_o} !== 4'b0) begin
            errors++; $display("FAIL midrun_reset: ldA,ldB,busy,done got %b want 0000", {ld_a_o, ld_b_o, busy_o, done_o});
        end
        @(negedge clk); rst_n = 1'b1;
        run_gcd(16'd48, 16'd18, 0, 12, 16'd6, 1'b0, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_start_ignored;
        test_zero_operand;
        test_reset_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
